// File: rtl/host_if_pkg.sv
// Shared definitions for the FT245 host interface and its Wishbone master
// stage: command codes, response status words, ID bytes and the bridge
// state encoding.
package host_if_pkg;

  localparam logic [3:0]  CMD_PING  = 4'd0;
  localparam logic [3:0]  CMD_WRITE = 4'd1;
  localparam logic [3:0]  CMD_READ  = 4'd2;

  localparam logic [31:0] STATUS_PING    = 32'hFFFF_FFFF;
  localparam logic [31:0] STATUS_WRITE   = 32'hFFFF_FFFE;
  localparam logic [31:0] STATUS_READ    = 32'hFFFF_FFFD;
  localparam logic [31:0] STATUS_TIMEOUT = 32'hFFFF_FFF0;

  localparam logic [7:0]  ID_BYTE0 = 8'hCD;
  localparam logic [7:0]  ID_BYTE1 = 8'hDC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_CYC,
    ST_WAIT_WR,
    ST_RESP,
    ST_HOLD
  } bridge_state_e;

  // Extra words after the first for a read request; a count of 0 means 1 word.
  function automatic logic [27:0] read_extra(input logic [27:0] count);
    return (count == 28'd0) ? 28'd0 : count - 28'd1;
  endfunction

endpackage

// File: rtl/wb_single_cycle.sv
// One classic Wishbone single cycle at a time: owns cyc/stb/we/sel, reports
// ack as done (with the read data alongside) and, when WB_BRIDGE_TIMEOUT_EN
// is defined, abandons a cycle that sees no ack within TIMEOUT_CYCLES clocks.
module wb_single_cycle
  import host_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        we_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i
);

  logic       cyc_q;
  logic       we_q;
  logic [3:0] sel_q;

  assign done_o    = cyc_q & wbm_ack_i;
  assign rdata_o   = wbm_dat_i;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // An ack in the final allowed cycle still wins over the timeout.
  assign timeout_o = cyc_q & ~wbm_ack_i & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count clocks spent in the current cycle without an ack.
  always_ff @(posedge clk) begin
    if (rst || start_i || !cyc_q || wbm_ack_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_o = 1'b0;
`endif

  // Raise cyc/stb on start; drop them on the edge that sees ack (or timeout).
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
    end else if (start_i) begin
      cyc_q <= 1'b1;
      we_q  <= we_i;
      sel_q <= 4'hF;
    end else if (done_o || timeout_o) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
    end
  end

endmodule

// File: rtl/wb_host_master_bridge.sv
// Wishbone master stage behind the FT245 host interface. Executes ping,
// write-burst and read-burst requests one Wishbone single cycle at a time and
// hands each response word to the host output handler. Optional ack timeout:
// define WB_BRIDGE_TIMEOUT_EN.
module wb_host_master_bridge
  import host_if_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  master_ready,
  input  logic                  ih_ready,
  input  logic [31:0]           in_command,
  input  logic [31:0]           in_address,
  input  logic [27:0]           in_data_count,
  input  logic [31:0]           in_data,
  input  logic                  oh_ready,
  output logic                  oh_en,
  output logic [31:0]           out_status,
  output logic [31:0]           out_address,
  output logic [27:0]           out_data_count,
  output logic [31:0]           out_data,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_cyc_o,
  input  logic                  wbm_ack_i
);

  bridge_state_e state_q;
  logic [3:0]    cmd_q;
  logic [31:0]   addr_q;
  logic [27:0]   remaining_q;
  logic [31:0]   wdat_q;
  logic          hold_arm_q;
  logic          oh_en_q;
  logic [31:0]   status_q;
  logic [31:0]   out_addr_q;
  logic [27:0]   out_cnt_q;
  logic [31:0]   out_data_q;

  logic [3:0]  cmd_in;
  logic        start_idle, start_wr, start_rd, start, start_we;
  logic        wb_done, wb_timeout;
  logic [31:0] wb_rdata;
  logic        unused_cmd_hi;

  assign cmd_in        = in_command[3:0];
  assign unused_cmd_hi = ^in_command[31:4];

  // A Wishbone cycle is launched from IDLE (new write/read), from WAIT_WR
  // (next write word) or from HOLD (next read word once the host is free).
  assign start_idle = (state_q == ST_IDLE) & ih_ready &
                      ((cmd_in == CMD_WRITE) | (cmd_in == CMD_READ));
  assign start_wr   = (state_q == ST_WAIT_WR) & ih_ready;
  assign start_rd   = (state_q == ST_HOLD) & hold_arm_q & oh_ready &
                      (cmd_q == CMD_READ) & (remaining_q != 28'd0);
  assign start      = start_idle | start_wr | start_rd;
  assign start_we   = start_idle ? (cmd_in == CMD_WRITE) : start_wr;

  assign master_ready   = (state_q == ST_IDLE) || (state_q == ST_WAIT_WR);
  assign oh_en          = oh_en_q;
  assign out_status     = status_q;
  assign out_address    = out_addr_q;
  assign out_data_count = out_cnt_q;
  assign out_data       = out_data_q;
  assign wbm_adr_o      = addr_q[ADDR_WIDTH-1:0];
  assign wbm_dat_o      = wdat_q;

  wb_single_cycle #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wb (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .we_i      (start_we),
    .done_o    (wb_done),
    .timeout_o (wb_timeout),
    .rdata_o   (wb_rdata),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );

  // Request sequencing and the registered response word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 4'd0;
      addr_q      <= 32'd0;
      remaining_q <= 28'd0;
      wdat_q      <= 32'd0;
      hold_arm_q  <= 1'b0;
      oh_en_q     <= 1'b0;
      status_q    <= 32'd0;
      out_addr_q  <= 32'd0;
      out_cnt_q   <= 28'd0;
      out_data_q  <= 32'd0;
    end else begin
      oh_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ih_ready) begin
            case (cmd_in)
              CMD_PING: begin
                cmd_q      <= cmd_in;
                addr_q     <= in_address;
                out_addr_q <= in_address;
                status_q   <= STATUS_PING;
                out_cnt_q  <= 28'd0;
                state_q    <= ST_RESP;
              end
              CMD_WRITE: begin
                cmd_q       <= cmd_in;
                addr_q      <= in_address;
                out_addr_q  <= in_address;
                wdat_q      <= in_data;
                remaining_q <= in_data_count;
                out_cnt_q   <= 28'd0;
                state_q     <= ST_WB_CYC;
              end
              CMD_READ: begin
                cmd_q       <= cmd_in;
                addr_q      <= in_address;
                out_addr_q  <= in_address;
                remaining_q <= read_extra(in_data_count);
                out_cnt_q   <= read_extra(in_data_count);
                state_q     <= ST_WB_CYC;
              end
              default: ;
            endcase
          end
        end
        ST_WB_CYC: begin
          if (wb_timeout) begin
            // Abandon the rest of the burst; report the failure once.
            status_q    <= STATUS_TIMEOUT;
            out_cnt_q   <= 28'd0;
            remaining_q <= 28'd0;
            state_q     <= ST_RESP;
          end else if (wb_done) begin
            if (cmd_q == CMD_READ) begin
              out_data_q <= wb_rdata;
              status_q   <= STATUS_READ;
              state_q    <= ST_RESP;
            end else if (remaining_q == 28'd0) begin
              status_q <= STATUS_WRITE;
              state_q  <= ST_RESP;
            end else begin
              remaining_q <= remaining_q - 28'd1;
              addr_q      <= addr_q + 32'd1;
              state_q     <= ST_WAIT_WR;
            end
          end
        end
        ST_WAIT_WR: begin
          if (ih_ready) begin
            wdat_q  <= in_data;
            state_q <= ST_WB_CYC;
          end
        end
        ST_RESP: begin
          hold_arm_q <= 1'b0;
          if (oh_ready) begin
            oh_en_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // The first HOLD cycle gives the host time to drop oh_ready; out_*
          // stay frozen until it comes back high.
          if (!hold_arm_q) begin
            hold_arm_q <= 1'b1;
          end else if (oh_ready) begin
            hold_arm_q <= 1'b0;
            if (start_rd) begin
              remaining_q <= remaining_q - 28'd1;
              addr_q      <= addr_q + 32'd1;
              state_q     <= ST_WB_CYC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master_bridge.sv
// Scoreboard bench for wb_host_master_bridge: a request driver pushes the
// expected Wishbone accesses and response words; a slave model and a host
// output model pop and compare them independently.
module tb_wb_host_master_bridge;

  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        master_ready;
  logic        ih_ready;
  logic [31:0] in_command, in_address, in_data;
  logic [27:0] in_data_count;
  logic        oh_ready;
  logic        oh_en;
  logic [31:0] out_status, out_address, out_data;
  logic [27:0] out_data_count;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;

  always #5 clk = ~clk;

  wb_host_master_bridge #(
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .master_ready(master_ready), .ih_ready(ih_ready),
    .in_command(in_command), .in_address(in_address), .in_data_count(in_data_count),
    .in_data(in_data), .oh_ready(oh_ready), .oh_en(oh_en), .out_status(out_status),
    .out_address(out_address), .out_data_count(out_data_count), .out_data(out_data),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } wb_exp_t;

  typedef struct {
    logic [31:0] status;
    logic [31:0] address;
    logic [27:0] dc;
    logic [31:0] data;
    bit          chk_dc;
    bit          chk_data;
  } rsp_exp_t;

  wb_exp_t     wb_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] ref_mem[bit [31:0]];
  logic [31:0] slv_mem[bit [31:0]];

  int n_pass = 0;
  int n_chk  = 0;
  int slv_fix_dly = -1;
  bit slv_no_ack  = 1'b0;
  bit force_rdy   = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Contents of never-written slave locations.
  function automatic logic [31:0] bg_pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg_pat(a);
  endfunction

  function automatic logic [31:0] cmd_word(input logic [3:0] c);
    logic [31:0] r;
    r = $urandom;
    return {r[31:4], c};
  endfunction

  task automatic send(input logic [31:0] cmd, input logic [31:0] a,
                      input logic [27:0] cnt, input logic [31:0] d);
    int w;
    w = 0;
    while (!master_ready && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    chk("master_ready before request", {31'd0, master_ready}, 32'd1);
    if (!master_ready) return;
    ih_ready = 1'b1; in_command = cmd; in_address = a; in_data_count = cnt; in_data = d;
    @(posedge clk); #1;
    ih_ready = 1'b0; in_command = $urandom; in_address = $urandom; in_data = $urandom;
  endtask

  task automatic push_rsp(input logic [31:0] st, input logic [31:0] a, input logic [27:0] dc,
                          input logic [31:0] d, input bit cdc, input bit cd);
    rsp_exp_t e;
    e.status = st; e.address = a; e.dc = dc; e.data = d; e.chk_dc = cdc; e.chk_data = cd;
    rsp_q.push_back(e);
  endtask

  task automatic do_ping(input logic [31:0] a);
    push_rsp(32'hFFFF_FFFF, a, 28'd0, 32'd0, 1'b1, 1'b0);
    send(cmd_word(4'd0), a, 28'($urandom), $urandom);
  endtask

  task automatic do_write(input logic [31:0] a, input int n, input logic [31:0] first, input bit chk_stb);
    logic [31:0] d[4];
    wb_exp_t     e;
    for (int i = 0; i < 4; i++) d[i] = (i == 0) ? first : $urandom;
    for (int i = 0; i < n; i++) begin
      e.adr = a + 32'(i); e.we = 1'b1; e.dat = d[i];
      wb_q.push_back(e);
      ref_mem[a + 32'(i)] = d[i];
    end
    push_rsp(32'hFFFF_FFFE, a, 28'd0, 32'd0, 1'b0, 1'b0);
    send(cmd_word(4'd1), a, 28'(n - 1), d[0]);
    if (chk_stb) chk("stb one clock after request", {31'd0, wbm_stb_o}, 32'd1);
    for (int i = 1; i < n; i++) send($urandom, $urandom, 28'($urandom), d[i]);
  endtask

  task automatic do_read(input logic [31:0] a, input int cnt);
    int      n;
    wb_exp_t e;
    n = (cnt == 0) ? 1 : cnt;
    for (int i = 0; i < n; i++) begin
      e.adr = a + 32'(i); e.we = 1'b0; e.dat = 32'd0;
      wb_q.push_back(e);
      push_rsp(32'hFFFF_FFFD, a, 28'(n - 1), ref_rd(a + 32'(i)), 1'b1, 1'b1);
    end
    send(cmd_word(4'd2), a, 28'(cnt), $urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((rsp_q.size() != 0 || wb_q.size() != 0) && w < 5000) begin
      @(posedge clk); #1; w++;
    end
    chk("responses drained", 32'(rsp_q.size()), 32'd0);
    chk("wishbone accesses drained", 32'(wb_q.size()), 32'd0);
    rsp_q.delete();
    wb_q.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Wishbone slave with variable ack latency; compares each acked access.
  initial begin : slave
    int      dly;
    bit      active;
    wb_exp_t e;
    dly = 0; active = 1'b0;
    wbm_ack_i = 1'b0; wbm_dat_i = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (wbm_ack_i) wbm_ack_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !rst) begin
        if (!active) begin
          active = 1'b1;
          dly = (slv_fix_dly >= 0) ? slv_fix_dly : int'($urandom_range(0, 3));
        end
        if (!slv_no_ack) begin
          if (dly == 0) begin
            chk("wishbone access expected", {31'd0, wb_q.size() > 0}, 32'd1);
            chk("sel during cycle", {28'd0, wbm_sel_o}, 32'hF);
            chk("master_ready low in cycle", {31'd0, master_ready}, 32'd0);
            if (wb_q.size() > 0) begin
              e = wb_q.pop_front();
              chk("wb adr", wbm_adr_o, e.adr);
              chk("wb we", {31'd0, wbm_we_o}, {31'd0, e.we});
              if (e.we) chk("wb write data", wbm_dat_o, e.dat);
            end
            if (wbm_we_o) slv_mem[wbm_adr_o] = wbm_dat_o;
            else wbm_dat_i = slv_mem.exists(wbm_adr_o) ? slv_mem[wbm_adr_o] : bg_pat(wbm_adr_o);
            wbm_ack_i = 1'b1;
            active = 1'b0;
          end else begin
            dly--;
          end
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // Host output handler: compares each oh_en word, checks it is held while
  // the host is busy, and drives oh_ready.
  initial begin : host_out
    int          busy;
    bit          stab_on, stab_bad;
    logic [31:0] cs, ca, cd;
    logic [27:0] cdc;
    rsp_exp_t    e;
    busy = 0; stab_on = 1'b0; stab_bad = 1'b0;
    cs = 0; ca = 0; cd = 0; cdc = 0;
    oh_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin stab_on = 1'b0; busy = 0; end
      if (stab_on) begin
        if (out_status !== cs || out_address !== ca || out_data !== cd || out_data_count !== cdc)
          stab_bad = 1'b1;
        if (oh_ready) begin
          chk("response held while host busy", {31'd0, stab_bad}, 32'd0);
          stab_on = 1'b0;
        end
      end
      if (oh_en) begin
        chk("response expected", {31'd0, rsp_q.size() > 0}, 32'd1);
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          chk("out_status", out_status, e.status);
          chk("out_address", out_address, e.address);
          if (e.chk_dc) chk("out_data_count", {4'd0, out_data_count}, {4'd0, e.dc});
          if (e.chk_data) chk("out_data", out_data, e.data);
        end
        cs = out_status; ca = out_address; cd = out_data; cdc = out_data_count;
        stab_on = 1'b1; stab_bad = 1'b0;
      end
      if (force_rdy) begin
        oh_ready = 1'b1;
      end else if (oh_en) begin
        busy = $urandom_range(1, 4);
        oh_ready = 1'b0;
      end else if (busy > 0) begin
        busy--;
        oh_ready = (busy == 0);
      end else begin
        oh_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst = 1'b1; ih_ready = 1'b0; in_command = 0; in_address = 0; in_data_count = 0; in_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset master_ready", {31'd0, master_ready}, 32'd1);
    chk("reset oh_en", {31'd0, oh_en}, 32'd0);
    chk("reset cyc/stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("reset we/sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
    chk("reset out_status", out_status, 32'd0);
    chk("reset out_address", out_address, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset adr", wbm_adr_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ping with oh_ready held high: oh_en two clocks after the request.
    force_rdy = 1'b1;
    push_rsp(32'hFFFF_FFFF, 32'h0000_1234, 28'd0, 32'd0, 1'b1, 1'b0);
    send(cmd_word(4'd0), 32'h0000_1234, 28'd5, 32'd0);
    chk("ping oh_en not yet", {31'd0, oh_en}, 32'd0);
    @(posedge clk); #1;
    chk("ping oh_en latency", {31'd0, oh_en}, 32'd1);
    drain();
    chk("master_ready after ping", {31'd0, master_ready}, 32'd1);

    // Single write, then a 3-word burst with ack held off 3 clocks.
    force_rdy = 1'b0;
    do_write(32'h10, 1, 32'hDEAD_BEEF, 1'b1);
    drain();
    slv_fix_dly = 3;
    do_write(32'h20, 3, $urandom, 1'b0);
    drain();
    slv_fix_dly = -1;

    // Burst read of known data, a wrapping read, write/read-back, count 0.
    slv_mem[32'h40] = 32'h1111_1111; ref_mem[32'h40] = 32'h1111_1111;
    slv_mem[32'h41] = 32'h2222_2222; ref_mem[32'h41] = 32'h2222_2222;
    do_read(32'h40, 2);
    drain();
    do_read(32'hFFFF_FFFF, 2);
    drain();
    do_write(32'h100, 4, $urandom, 1'b0);
    do_read(32'h100, 4);
    drain();
    do_read(32'h200, 0);
    drain();

    // Unknown command is dropped; the next ping is answered normally.
    send(cmd_word(4'd7), 32'h300, 28'd0, 32'd0);
    do_ping(32'h0BAD_F00D);
    drain();

    // Randomised traffic, some of it straddling the address wrap.
    for (int t = 0; t < 40; t++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      case (k)
        0:       do_ping(a);
        1:       do_write(a, $urandom_range(1, 4), $urandom, 1'b0);
        default: do_read(a, $urandom_range(0, 4));
      endcase
    end
    drain();

`ifdef WB_BRIDGE_TIMEOUT_EN
    // Read that never sees ack: one timeout response, burst abandoned.
    slv_no_ack = 1'b1;
    push_rsp(32'hFFFF_FFF0, 32'h500, 28'd0, 32'd0, 1'b1, 1'b0);
    send(cmd_word(4'd2), 32'h500, 28'd3, 32'd0);
    n = 0;
    while (wbm_cyc_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("timeout cyc length", 32'(n), 32'(TO_CYC));
    slv_no_ack = 1'b0;
    drain();
    repeat (8) @(posedge clk);
    #1;
    chk("idle after timeout", {31'd0, master_ready}, 32'd1);
`endif

    // Reset while a read cycle is outstanding.
    slv_no_ack = 1'b1;
    send(cmd_word(4'd2), 32'h600, 28'd2, 32'd0);
    chk("stb before mid-read reset", {31'd0, wbm_stb_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid-read reset cyc/stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("mid-read reset oh_en", {31'd0, oh_en}, 32'd0);
    chk("mid-read reset master_ready", {31'd0, master_ready}, 32'd1);
    rst = 1'b0;
    slv_no_ack = 1'b0;
    @(posedge clk); #1;
    do_ping(32'h0000_0777);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
